// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: memory FSM
// encodings, register-file constants and the pipeline control bundle.
package hazard_ctrl_pkg;

  typedef enum logic {
    MEMST_IDLE = 1'b0,
    MEMST_BUSY = 1'b1
  } memst_e;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         LENGTH_DEF   = 32;
  localparam int         WAIT_CNT_W   = 8;
  localparam int         WAIT_MAX_DEF = 15;

  // Enables and flushes for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_src;
  } pipe_ctl_t;

  // A load in ID/EX whose destination feeds an operand of the ID instruction.
  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] dst,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    return memread && (dst != REG_ZERO) && ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_dmem_handshake.sv
// Data-memory request/acknowledge handshake for the load or store in EX/MEM,
// with a bounded wait and a sticky timeout flag.
module dmem_handshake
  import hazard_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst_i,
  input  logic   exmem_memread_i,
  input  logic   exmem_memwrite_i,
  input  logic   dmem_ack_i,
  output logic   dmem_req_o,
  output logic   mem_err_o,
  output logic   mem_stall_o,
  output memst_e state_o
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);

  memst_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  dmem_req_q, dmem_req_d;
  logic                  mem_err_q, mem_err_d;
  logic                  mem_op;

  assign mem_op = exmem_memread_i | exmem_memwrite_i;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dmem_req_d  = dmem_req_q;
    mem_err_d   = mem_err_q;
    mem_stall_o = 1'b0;
    case (state_q)
      MEMST_IDLE: begin
        if (mem_op) begin
          state_d     = MEMST_BUSY;
          dmem_req_d  = 1'b1;
          wait_cnt_d  = '0;
          mem_stall_o = 1'b1;
        end
      end
      MEMST_BUSY: begin
        if (dmem_ack_i) begin
          state_d    = MEMST_IDLE;
          dmem_req_d = 1'b0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Last allowed BUSY cycle: give up and let the instruction retire.
          state_d    = MEMST_IDLE;
          dmem_req_d = 1'b0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d  = wait_cnt_q + WAIT_CNT_W'(1);
          mem_stall_o = 1'b1;
        end
      end
      default: state_d = MEMST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q    <= MEMST_IDLE;
      wait_cnt_q <= '0;
      dmem_req_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dmem_req_q <= dmem_req_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign dmem_req_o = dmem_req_q;
  assign mem_err_o  = mem_err_q;
  assign state_o    = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory wait > taken branch > load-use.
// Define HAZARD_PERF_CNT_EN to add the stall/flush/memory cycle counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LENGTH   = LENGTH_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       idex_memread,
  input  logic [4:0] idex_dst,
  input  logic       exmem_memread,
  input  logic       exmem_memwrite,
  input  logic       exmem_branch,
  input  logic       exmem_zero,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       pc_src,
`ifdef HAZARD_PERF_CNT_EN
  output logic [LENGTH-1:0] stall_cycles,
  output logic [LENGTH-1:0] flush_events,
  output logic [LENGTH-1:0] mem_cycles,
`endif
  output logic       mem_err
);

  memst_e    mem_state;
  logic      mem_stall;
  logic      br_taken;
  logic      load_use;
  pipe_ctl_t ctl;

  dmem_handshake #(.WAIT_MAX(WAIT_MAX)) u_dmem (
    .clk              (clk),
    .rst_i            (rst),
    .exmem_memread_i  (exmem_memread),
    .exmem_memwrite_i (exmem_memwrite),
    .dmem_ack_i       (dmem_ack),
    .dmem_req_o       (dmem_req),
    .mem_err_o        (mem_err),
    .mem_stall_o      (mem_stall),
    .state_o          (mem_state)
  );

  // Effective hazards: each is masked by everything above it in priority.
  assign br_taken = rst & ~mem_stall & exmem_branch & exmem_zero;
  assign load_use = rst & ~mem_stall & ~br_taken &
                    load_use_hit(idex_memread, idex_dst, id_rs, id_rt);

  always_comb begin
    ctl = '0;
    if (!rst || mem_stall) begin
      ctl = '0;
    end else if (br_taken) begin
      ctl = '1;
    end else if (load_use) begin
      ctl.idex_en    = 1'b1;
      ctl.exmem_en   = 1'b1;
      ctl.memwb_en   = 1'b1;
      ctl.idex_flush = 1'b1;
    end else begin
      ctl.pc_en    = 1'b1;
      ctl.ifid_en  = 1'b1;
      ctl.idex_en  = 1'b1;
      ctl.exmem_en = 1'b1;
      ctl.memwb_en = 1'b1;
    end
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign idex_en     = ctl.idex_en;
  assign exmem_en    = ctl.exmem_en;
  assign memwb_en    = ctl.memwb_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign pc_src      = ctl.pc_src;

  // The request line is exactly the BUSY state seen from outside.
  a_req_tracks_busy: assert property (@(posedge clk) disable iff (!rst)
    (mem_state == MEMST_BUSY) == dmem_req);

`ifdef HAZARD_PERF_CNT_EN
  logic [LENGTH-1:0] stall_cycles_q, flush_events_q, mem_cycles_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      mem_cycles_q   <= '0;
    end else begin
      if (mem_stall || load_use) stall_cycles_q <= stall_cycles_q + LENGTH'(1);
      if (br_taken)              flush_events_q <= flush_events_q + LENGTH'(1);
      if (mem_state == MEMST_BUSY) mem_cycles_q <= mem_cycles_q + LENGTH'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign mem_cycles   = mem_cycles_q;
`endif

endmodule
